mor1kx_pic_sched: RTL
=====================

# mor1kx_pic_sched

Interrupt scheduler between the PIC status/mask registers and the CPU exception logic. It takes the masked pending vector (PICSR), selects one line by fixed or round-robin priority, and presents it to the exception unit as a request/acknowledge handshake. It tracks in-service lines until software signals end-of-interrupt (EOI), which gives priority nesting in fixed mode and fairness in round-robin mode. A programmable hold-off gap follows each accepted interrupt.

## Interface
- OPTION_ARB, "FIXED", arbitration: "FIXED" (line 0 highest) or "RR" (round-robin); any other value is a fatal elaboration error.
- OPTION_HOLDOFF, 0, idle cycles enforced after each acknowledge (0–255).
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- picsr_i  in  32  pending vector from PIC status register (already masked by PICMR).
- iee_i  in  1  SR interrupt-enable; 0 blocks new requests.
- irq_ack_i  in  1  exception unit accepts current request (valid only while irq_req_o=1).
- eoi_i  in  1  one-cycle EOI strobe.
- eoi_id_i  in  5  line being retired by EOI.
- irq_req_o  out  1  interrupt request to exception unit.
- irq_id_o  out  5  selected line; stable while irq_req_o=1.
- insvc_o  out  32  in-service vector.
- eoi_err_o  out  1  one-cycle pulse: EOI named a line not in service.
- busy_o  out  1  state != IDLE.

## Operation
- Reset (rst_n=0 at edge): state IDLE, irq_req_o=0, irq_id_o=0, insvc_o=0, eoi_err_o=0, busy_o=0, RR pointer=0, hold-off counter=0. Reset overrides any in-flight request or EOI; req drops at that edge.
- Eligible vector (combinational):
  - FIXED: picsr_i bit i eligible iff i < lowest set index of insvc (all bits if insvc=0). Only strictly higher priority preempts.
  - RR: picsr_i & ~insvc.
- Winner: FIXED = lowest eligible index. RR = first eligible index at or above the pointer, wrapping 31→0. On ack the pointer becomes (winner+1) mod 32.
- FSM:
  - IDLE: eligible!=0 and iee_i=1 → ARB.
  - ARB: latch the winner into irq_id_o and → REQ (irq_req_o=1). If eligible became 0 or iee_i=0, → IDLE.
  - REQ: irq_id_o is frozen.
    - irq_ack_i=1: set insvc[irq_id_o], update RR pointer, → HOLD if OPTION_HOLDOFF>0, else IDLE.
    - Otherwise, if picsr_i[irq_id_o]=0 or iee_i=0: retract the request (→ IDLE, no insvc change).
    - A higher-priority line arriving during REQ does not replace irq_id_o.
  - HOLD: counter loads OPTION_HOLDOFF-1 on entry, decrements each cycle, → IDLE when it reaches 0.
- EOI: on eoi_i=1, clear insvc[eoi_id_i]. If that bit was already 0, pulse eoi_err_o on the next cycle and leave insvc unchanged. EOI is accepted in any state.
- Simultaneous ack and EOI:
  - Different lines: both take effect.
  - Same line: the EOI is evaluated against the pre-edge insvc, then the ack sets the bit. The bit ends at 1, and eoi_err_o pulses if the bit was 0 before the edge.
- Ack wins over retraction in the same cycle.

## Timing
- picsr_i rises at cycle N (state IDLE, iee_i=1): ARB at N+1, irq_req_o=1 and irq_id_o valid at N+2.
- Ack sampled at edge E: irq_req_o=0 and insvc bit set from E. With OPTION_HOLDOFF=H, the next ARB is no earlier than E+H+1; next request no earlier than E+H+2.
- Retraction: irq_req_o low one cycle after the condition is sampled.
- EOI at edge E: insvc cleared from E. A newly eligible line can reach ARB at E+1 if the FSM is IDLE.
- eoi_err_o is high for exactly one cycle.
- All outputs are registered except busy_o, which is decoded from state.

## Test plan
- Reset: drive picsr_i=0xFFFFFFFF with rst_n=0 for 3 cycles → irq_req_o=0, insvc_o=0. Release reset → irq_req_o=1 with irq_id_o=0 two cycles later.
- FIXED nesting: picsr=0x10, ack → insvc=0x10. Assert picsr=0x14 → req id=2 (preempts 4). Ack → insvc=0x14. Raise picsr bit 8 → no request. EOI id 2 then EOI id 4 → req id=8.
- RR fairness (OPTION_ARB="RR"): picsr=0x0000000F held, ack and EOI each grant immediately → ids 0,1,2,3,0.
- Retraction and ack priority:
  - picsr bit 5 drops during REQ with no ack → req low next cycle, insvc=0.
  - Repeat with ack in the same cycle as the drop → insvc=0x20.
- Hold-off: OPTION_HOLDOFF=4, picsr=0x3, ack at cycle 10 → next irq_req_o rises at cycle 16.
- EOI errors: EOI id 7 with insvc=0 → eoi_err_o high for one cycle, insvc=0. Ack and EOI for id 3 in the same cycle, bit previously 0 → insvc[3]=1 and eoi_err_o pulses.

Source files
------------

// File: rtl/mor1kx_pic_sched.sv
// Interrupt scheduler: picks one pending PIC line by fixed or round-robin priority,
// drives a req/ack handshake to the exception unit and tracks in-service lines until EOI.
module mor1kx_pic_sched #(
  parameter string OPTION_ARB     = "FIXED",
  parameter int    OPTION_HOLDOFF = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] picsr_i,
  input  logic        iee_i,
  input  logic        irq_ack_i,
  input  logic        eoi_i,
  input  logic [4:0]  eoi_id_i,
  output logic        irq_req_o,
  output logic [4:0]  irq_id_o,
  output logic [31:0] insvc_o,
  output logic        eoi_err_o,
  output logic        busy_o
);

  localparam bit ARB_RR = (OPTION_ARB == "RR");
  localparam logic [7:0] HOLD_LOAD = 8'(OPTION_HOLDOFF > 0 ? OPTION_HOLDOFF - 1 : 0);

  generate
    if (OPTION_ARB != "FIXED" && OPTION_ARB != "RR") begin : g_bad_arb
      $fatal(1, "mor1kx_pic_sched: OPTION_ARB must be FIXED or RR");
    end
    if (OPTION_HOLDOFF < 0 || OPTION_HOLDOFF > 255) begin : g_bad_holdoff
      $fatal(1, "mor1kx_pic_sched: OPTION_HOLDOFF must be 0..255");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_REQ, S_HOLD} state_t;

  state_t      state_q;
  logic        irq_req_q;
  logic [4:0]  irq_id_q;
  logic [31:0] insvc_q, insvc_d;
  logic        eoi_err_q;
  logic [4:0]  ptr_q;
  logic [7:0]  hold_q;

  logic [31:0] ins_lowest;
  logic [31:0] eligible;
  logic        any_elig;
  logic [4:0]  winner;
  logic        found;
  logic [4:0]  idx;
  logic        ack_take;

  // Fixed mode: only lines strictly below the lowest in-service line may preempt.
  // With nothing in service, lowest-1 wraps to all ones, making every line eligible.
  always_comb begin
    ins_lowest = insvc_q & (~insvc_q + 32'd1);
    eligible   = ARB_RR ? (picsr_i & ~insvc_q) : (picsr_i & (ins_lowest - 32'd1));
    any_elig   = |eligible;
  end

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < 32; i++) begin
      idx = ARB_RR ? (ptr_q + 5'(i)) : 5'(i);
      if (!found && eligible[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // EOI clears against the pre-edge vector; a same-cycle ack then sets its bit.
  always_comb begin
    ack_take = (state_q == S_REQ) && irq_ack_i;
    insvc_d  = insvc_q;
    if (eoi_i)
      insvc_d[eoi_id_i] = 1'b0;
    if (ack_take)
      insvc_d[irq_id_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      irq_req_q <= 1'b0;
      irq_id_q  <= '0;
      insvc_q   <= '0;
      eoi_err_q <= 1'b0;
      ptr_q     <= '0;
      hold_q    <= '0;
    end else begin
      insvc_q   <= insvc_d;
      eoi_err_q <= eoi_i & ~insvc_q[eoi_id_i];
      case (state_q)
        S_IDLE: begin
          if (any_elig && iee_i)
            state_q <= S_ARB;
        end
        S_ARB: begin
          if (!any_elig || !iee_i) begin
            state_q <= S_IDLE;
          end else begin
            irq_id_q  <= winner;
            irq_req_q <= 1'b1;
            state_q   <= S_REQ;
          end
        end
        S_REQ: begin
          if (irq_ack_i) begin
            irq_req_q <= 1'b0;
            ptr_q     <= irq_id_q + 5'd1;
            if (OPTION_HOLDOFF > 0) begin
              hold_q  <= HOLD_LOAD;
              state_q <= S_HOLD;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (!picsr_i[irq_id_q] || !iee_i) begin
            irq_req_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (hold_q == 8'd0)
            state_q <= S_IDLE;
          else
            hold_q <= hold_q - 8'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign irq_req_o = irq_req_q;
  assign irq_id_o  = irq_id_q;
  assign insvc_o   = insvc_q;
  assign eoi_err_o = eoi_err_q;
  assign busy_o    = (state_q != S_IDLE);

endmodule
